// File: rtl/signed_mac_alu_if.sv
// Operand/result bundle for signed_mac_alu: in_valid with A/B/C in, out_valid with OUT back.
// The master drives operands; the slave (the datapath) returns registered results.
interface signed_mac_alu_if #(
    parameter int W = 4
);
    logic             in_valid;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [W-1:0]     C;
    logic             out_valid;
    logic [2*W-1:0]   OUT;

    modport master (
        output in_valid, A, B, C,
        input  out_valid, OUT
    );

    modport slave (
        input  in_valid, A, B, C,
        output out_valid, OUT
    );
endinterface

// File: rtl/signed_mac_alu.sv
// signed_mac_alu: registered OUT = A + B*C, A/B signed, C unsigned, OUT signed 2*W bits.
// Define ALU_PIPE_EN to register the product ahead of the add (latency 2 instead of 1).
module signed_mac_alu #(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst,
    signed_mac_alu_if.slave bus
);
    localparam int PW = 2*W + 1;
    localparam int OW = 2*W;

    logic signed [W:0]    b_ext;
    logic signed [W:0]    c_ext;
    logic signed [PW-1:0] prod;

    logic [W-1:0]         add_a;
    logic signed [PW-1:0] add_p;
    logic                 add_v;
    logic signed [PW-1:0] a_ext;
    logic signed [OW-1:0] sum;

    logic [OW-1:0]        out_q;
    logic [OW-1:0]        out_d;
    logic                 out_valid_q;
    logic                 out_valid_d;

    // C gets a zero sign bit so 4'b1111 multiplies as 15, never -1.
    always_comb begin
        b_ext = {bus.B[W-1], bus.B};
        c_ext = {1'b0, bus.C};
        prod  = PW'(b_ext * c_ext);
    end

`ifdef ALU_PIPE_EN
    logic signed [PW-1:0] prod_q;
    logic signed [PW-1:0] prod_d;
    logic [W-1:0]         a_q;
    logic [W-1:0]         a_d;
    logic                 v1_q;
    logic                 v1_d;

    always_comb begin
        prod_d = prod_q;
        a_d    = a_q;
        v1_d   = bus.in_valid;
        if (bus.in_valid) begin
            prod_d = prod;
            a_d    = bus.A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            a_q    <= '0;
            v1_q   <= 1'b0;
        end else begin
            prod_q <= prod_d;
            a_q    <= a_d;
            v1_q   <= v1_d;
        end
    end

    always_comb begin
        add_a = a_q;
        add_p = prod_q;
        add_v = v1_q;
    end
`else
    always_comb begin
        add_a = bus.A;
        add_p = prod;
        add_v = bus.in_valid;
    end
`endif

    // The full-width sum always fits in OW bits, so truncation loses nothing.
    always_comb begin
        a_ext = {{(W+1){add_a[W-1]}}, add_a};
        sum   = OW'(a_ext + add_p);
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = add_v;
        if (add_v) begin
            out_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.OUT       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_signed_mac_alu.sv
// Bench for signed_mac_alu (W=4): directed vector table, back-to-back, reset-in-flight,
// and a full A/B/C sweep, all checked through an expected-result queue with due cycles.
module tb_signed_mac_alu;
`ifdef ALU_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] val;
        int         due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tot;
    int   bad;
    int   run_len;
    int   max_run;
    exp_t sb[$];
    vec_t tbl[5];

    signed_mac_alu_if #(.W(4)) bus ();

    signed_mac_alu #(.W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_mac(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] c);
        int          av;
        int          bv;
        int          cv;
        logic [31:0] r;
        av = int'($signed(a));
        bv = int'($signed(b));
        cv = int'(c);
        r  = 32'(av + bv * cv);
        return r[7:0];
    endfunction

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tot++;
                bad++;
                $display("FAIL unexpected_out: got OUT=0x%0h with out_valid=1, want no result (cycle %0d)",
                         bus.OUT, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(bus.OUT), 32'(e.val));
                chk("latency", cyc, e.due);
            end
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [7:0] e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.C        = c;
        sb.push_back('{val: e, due: cyc + LAT});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = 4'($urandom);
        bus.B        = 4'($urandom);
        bus.C        = 4'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        tbl[0] = '{a: 4'hB, b: 4'hB, c: 4'hA, exp: 8'hC9};
        tbl[1] = '{a: 4'h3, b: 4'h3, c: 4'hA, exp: 8'h21};
        tbl[2] = '{a: 4'h7, b: 4'h7, c: 4'hF, exp: 8'h70};
        tbl[3] = '{a: 4'h8, b: 4'h8, c: 4'hF, exp: 8'h80};
        tbl[4] = '{a: 4'hA, b: 4'hA, c: 4'hA, exp: 8'hBE};

        cyc = 0; tot = 0; bad = 0; run_len = 0; max_run = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.A = 4'h0; bus.B = 4'h0; bus.C = 4'h0;

        // reset with random traffic on the inputs
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'($urandom);
            bus.A = 4'($urandom); bus.B = 4'($urandom); bus.C = 4'($urandom);
            @(negedge clk);
            chk("rst_out", 32'(bus.OUT), 32'h00);
            chk("rst_valid", 32'(bus.out_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_out", 32'(bus.OUT), 32'h00);
            chk("idle_valid", 32'(bus.out_valid), 32'h0);
            idle();
        end

        // directed vectors one at a time
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].exp);
            idle();
            drain();
        end

        // same vectors back-to-back, then hold
        max_run = 0;
        for (int i = 0; i < 5; i++) send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].exp);
        idle();
        drain();
        chk("b2b_run", max_run, 5);
        @(negedge clk);
        chk("hold_valid", 32'(bus.out_valid), 32'h0);
        chk("hold_out", 32'(bus.OUT), 32'hBE);
        repeat (2) idle();

        // reset while operations are in flight
        send(tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].exp);
        send(tbl[1].a, tbl[1].b, tbl[1].c, tbl[1].exp);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.A = tbl[2].a; bus.B = tbl[2].b; bus.C = tbl[2].c;
        while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        chk("flush_out", 32'(bus.OUT), 32'h00);
        repeat (4) idle();
        drain();

        // exhaustive sweep with random gaps
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 16; c++) begin
                    if ($urandom_range(0, 3) == 0) idle();
                    send(4'(a), 4'(b), 4'(c), ref_mac(4'(a), 4'(b), 4'(c)));
                end
            end
        end
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
